// File: rtl/cw_table_sel.sv
// Double-buffered codeword table. A shadow bank is loaded by streaming writes and swapped in at a symbol boundary.
// Each beam lane looks up an even/odd codeword pair by symbol-phase default or by beam index, with two cycles of latency.
module cw_table_sel #(
    parameter int ANTS      = 32,
    parameter int WIDTH     = 32,
    parameter int BEAM      = 16,
    parameter int DEPTH     = 64,
    parameter int NUM_PHASE = 4,
    parameter int AW        = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_wr_vld,
    output logic                         o_wr_rdy,
    input  logic [WIDTH*ANTS-1:0]        i_wr_even,
    input  logic [WIDTH*ANTS-1:0]        i_wr_odd,
    input  logic                         i_wr_last,
    input  logic                         i_symb_1st,
    input  logic [7:0]                   i_symb_idx,
    input  logic                         i_rbg_load,
    input  logic [BEAM*AW-1:0]           i_beam_idx,
    output logic [BEAM*WIDTH*ANTS-1:0]   o_cw_even,
    output logic [BEAM*WIDTH*ANTS-1:0]   o_cw_odd,
    output logic                         o_sel_vld,
    output logic                         o_tvalid,
    output logic                         o_bank,
    output logic                         o_err
);

    localparam int CW   = WIDTH * ANTS;
    localparam int CNTW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] mem_even [2][DEPTH];
    logic [CW-1:0] mem_odd  [2][DEPTH];

    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic            swap_pend_q, swap_pend_d;
    logic            bank_q, bank_d;
    logic            tvalid_q, tvalid_d;
    logic            wr_acc, wr_at_end, commit, wr_err, swap, req;
    logic [7:0]      phase;

    logic            vld_p0_q;
    logic            bank_p0_q;
    logic [AW-1:0]   idx_p0_q [BEAM];
    logic [AW-1:0]   idx_p0_d [BEAM];

    logic                 vld_p1_q;
    logic                 err_q, err_d, rd_err;
    logic [BEAM*CW-1:0]   cw_even_p1_q, cw_even_p1_d;
    logic [BEAM*CW-1:0]   cw_odd_p1_q, cw_odd_p1_d;

    // Write path, commit and bank swap control
    always_comb begin
        wr_acc    = i_wr_vld && !swap_pend_q;
        wr_at_end = (wr_cnt_q == CNTW'(DEPTH - 1));
        commit    = wr_acc && i_wr_last && wr_at_end;
        wr_err    = wr_acc && (i_wr_last != wr_at_end);
        // With no live table the first commit swaps straight away; otherwise wait for a symbol boundary.
        swap      = (commit && !tvalid_q) || (swap_pend_q && tvalid_q && i_symb_1st);

        wr_cnt_d = wr_cnt_q;
        if (wr_acc) begin
            wr_cnt_d = (i_wr_last || wr_at_end) ? '0 : wr_cnt_q + 1'b1;
        end

        swap_pend_d = swap_pend_q;
        if (swap) begin
            swap_pend_d = 1'b0;
        end else if (commit) begin
            swap_pend_d = 1'b1;
        end

        bank_d   = bank_q ^ swap;
        tvalid_d = tvalid_q | swap;
        req      = tvalid_d && (i_symb_1st || i_rbg_load);
    end

    // Stage p0: per-lane index capture
    always_comb begin
        phase    = i_symb_idx & 8'(NUM_PHASE - 1);
        idx_p0_d = '{default: '0};
        for (int b = 0; b < BEAM; b++) begin
            if (i_symb_1st) begin
                idx_p0_d[b] = AW'(int'(phase) * BEAM + b);
            end else begin
                idx_p0_d[b] = i_beam_idx[b*AW +: AW];
            end
        end
    end

    // Stage p1: table read, out-of-range lanes forced to zero
    always_comb begin
        cw_even_p1_d = '0;
        cw_odd_p1_d  = '0;
        rd_err       = 1'b0;
        for (int b = 0; b < BEAM; b++) begin
            if (int'(idx_p0_q[b]) < DEPTH) begin
                cw_even_p1_d[b*CW +: CW] = mem_even[bank_p0_q][idx_p0_q[b][CNTW-1:0]];
                cw_odd_p1_d[b*CW +: CW]  = mem_odd[bank_p0_q][idx_p0_q[b][CNTW-1:0]];
            end else begin
                rd_err = 1'b1;
            end
        end
        err_d = wr_err || (vld_p0_q && rd_err);
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_reset) begin
            mem_even[~bank_q][wr_cnt_q] <= i_wr_even;
            mem_odd[~bank_q][wr_cnt_q]  <= i_wr_odd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (req) begin
            idx_p0_q  <= idx_p0_d;
            bank_p0_q <= bank_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_cnt_q     <= '0;
            swap_pend_q  <= 1'b0;
            bank_q       <= 1'b0;
            tvalid_q     <= 1'b0;
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            err_q        <= 1'b0;
            cw_even_p1_q <= '0;
            cw_odd_p1_q  <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            swap_pend_q <= swap_pend_d;
            bank_q      <= bank_d;
            tvalid_q    <= tvalid_d;
            vld_p0_q    <= req;
            vld_p1_q    <= vld_p0_q;
            err_q       <= err_d;
            if (vld_p0_q) begin
                cw_even_p1_q <= cw_even_p1_d;
                cw_odd_p1_q  <= cw_odd_p1_d;
            end
        end
    end

    assign o_wr_rdy  = !swap_pend_q;
    assign o_cw_even = cw_even_p1_q;
    assign o_cw_odd  = cw_odd_p1_q;
    assign o_sel_vld = vld_p1_q;
    assign o_tvalid  = tvalid_q;
    assign o_bank    = bank_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_cw_table_sel.sv
// Randomized bench for cw_table_sel against a table-level reference model (active/shadow contents, not banks).
module tb_cw_table_sel;

    localparam int ANTS = 32, WIDTH = 32, BEAM = 16, DEPTH = 64, NUM_PHASE = 4, AW = 8;
    localparam int CW = WIDTH * ANTS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 i_reset, i_wr_vld, i_wr_last, i_symb_1st, i_rbg_load;
    logic [CW-1:0]        i_wr_even, i_wr_odd;
    logic [7:0]           i_symb_idx;
    logic [BEAM*AW-1:0]   i_beam_idx;
    logic                 o_wr_rdy, o_sel_vld, o_tvalid, o_bank, o_err;
    logic [BEAM*CW-1:0]   o_cw_even, o_cw_odd;

    cw_table_sel #(.ANTS(ANTS), .WIDTH(WIDTH), .BEAM(BEAM), .DEPTH(DEPTH),
                   .NUM_PHASE(NUM_PHASE), .AW(AW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_wr_vld(i_wr_vld), .o_wr_rdy(o_wr_rdy),
        .i_wr_even(i_wr_even), .i_wr_odd(i_wr_odd), .i_wr_last(i_wr_last),
        .i_symb_1st(i_symb_1st), .i_symb_idx(i_symb_idx), .i_rbg_load(i_rbg_load),
        .i_beam_idx(i_beam_idx), .o_cw_even(o_cw_even), .o_cw_odd(o_cw_odd),
        .o_sel_vld(o_sel_vld), .o_tvalid(o_tvalid), .o_bank(o_bank), .o_err(o_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: live table contents, shadow contents being loaded, and observable status.
    logic [CW-1:0]      act_e [DEPTH], act_o [DEPTH], shd_e [DEPTH], shd_o [DEPTH];
    int                 m_cnt = 0;
    bit                 m_pend = 0, m_tv = 0, m_bank = 0;
    logic [BEAM*CW-1:0] m_out_e = '0, m_out_o = '0;
    bit                 e_vld = 0, e_err = 0;
    logic [BEAM*CW-1:0] e_e = '0, e_o = '0;

    function automatic logic [CW-1:0] rnd_cw();
        logic [CW-1:0] v;
        for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BEAM*AW-1:0] rnd_bi(input int pct_out);
        logic [BEAM*AW-1:0] v;
        for (int b = 0; b < BEAM; b++) begin
            if ($urandom_range(0, 99) < pct_out) v[b*AW +: AW] = 8'($urandom_range(DEPTH, 255));
            else                                 v[b*AW +: AW] = 8'($urandom_range(0, DEPTH - 1));
        end
        return v;
    endfunction

    task automatic cyc(input bit rst, input bit wv, input bit wl, input logic [CW-1:0] we,
                       input logic [CW-1:0] wo, input bit s1, input bit rl,
                       input logic [7:0] si, input logic [BEAM*AW-1:0] bi);
        bit acc, commit, werr, swp, nv, nerr, xv, xerr;
        logic [BEAM*CW-1:0] ne, no;
        int idx;
        i_reset = rst; i_wr_vld = wv; i_wr_last = wl; i_wr_even = we; i_wr_odd = wo;
        i_symb_1st = s1; i_rbg_load = rl; i_symb_idx = si; i_beam_idx = bi;
        nv = 0; nerr = 0; werr = 0; commit = 0; ne = '0; no = '0;
        if (!rst) begin
            chk("wr_rdy", o_wr_rdy, !m_pend);
            acc = wv && !m_pend;
            if (acc) begin
                shd_e[m_cnt] = we;
                shd_o[m_cnt] = wo;
                if (wl && m_cnt == DEPTH - 1) commit = 1;
                else if (wl || m_cnt == DEPTH - 1) werr = 1;
                m_cnt = (wl || m_cnt == DEPTH - 1) ? 0 : m_cnt + 1;
            end
            swp = (commit && !m_tv) || (m_pend && m_tv && s1);
            if (commit && m_tv) m_pend = 1;
            if (swp) begin
                act_e = shd_e; act_o = shd_o;
                m_bank = !m_bank; m_tv = 1; m_pend = 0;
            end
            if (m_tv && (s1 || rl)) begin
                nv = 1;
                for (int b = 0; b < BEAM; b++) begin
                    idx = s1 ? (int'(si) % NUM_PHASE) * BEAM + b : int'(bi[b*AW +: AW]);
                    if (idx >= DEPTH) nerr = 1;
                    else begin
                        ne[b*CW +: CW] = act_e[idx];
                        no[b*CW +: CW] = act_o[idx];
                    end
                end
            end
        end
        @(posedge clk); #1;
        if (rst) begin
            m_cnt = 0; m_pend = 0; m_tv = 0; m_bank = 0;
            m_out_e = '0; m_out_o = '0;
            xv = 0; xerr = 0;
        end else begin
            xv = e_vld;
            xerr = (e_vld && e_err) || werr;
            if (e_vld) begin m_out_e = e_e; m_out_o = e_o; end
        end
        chk("sel_vld", o_sel_vld, xv);
        chk("err", o_err, xerr);
        chk("tvalid", o_tvalid, m_tv);
        chk("bank", o_bank, m_bank);
        for (int b = 0; b < BEAM; b++) begin
            for (int s = 0; s < CW / 256; s++) begin
                chk($sformatf("even_l%0d_s%0d", b, s), o_cw_even[b*CW + s*256 +: 256], m_out_e[b*CW + s*256 +: 256]);
                chk($sformatf("odd_l%0d_s%0d", b, s), o_cw_odd[b*CW + s*256 +: 256], m_out_o[b*CW + s*256 +: 256]);
            end
        end
        e_vld = nv; e_err = nerr; e_e = ne; e_o = no;
        i_reset = 0; i_wr_vld = 0; i_wr_last = 0; i_symb_1st = 0; i_rbg_load = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, 0, 8'd0, '0);
    endtask

    task automatic wr(input logic [CW-1:0] we, input logic [CW-1:0] wo, input bit last);
        cyc(0, 1, last, we, wo, 0, 0, 8'd0, '0);
    endtask

    task automatic req(input bit s1, input bit rl, input logic [7:0] si, input logic [BEAM*AW-1:0] bi);
        cyc(0, 0, 0, '0, '0, s1, rl, si, bi);
    endtask

    task automatic load_k(input int ofs);
        for (int k = 0; k < DEPTH; k++) wr(CW'(k + ofs), ~CW'(k + ofs), k == DEPTH - 1);
    endtask

    task automatic load_rnd();
        for (int k = 0; k < DEPTH; k++) wr(rnd_cw(), rnd_cw(), k == DEPTH - 1);
    endtask

    initial begin
        logic [BEAM*AW-1:0] bi;
        i_reset = 1; i_wr_vld = 0; i_wr_last = 0; i_wr_even = '0; i_wr_odd = '0;
        i_symb_1st = 0; i_symb_idx = '0; i_rbg_load = 0; i_beam_idx = '0;

        repeat (3) cyc(1, 0, 0, '0, '0, 0, 0, 8'd0, '0);
        idle(2);
        load_k(0);
        idle(1);
        req(1, 0, 8'd6, rnd_bi(0));
        idle(3);
        bi = rnd_bi(0);
        bi[0*AW +: AW] = 8'd5; bi[15*AW +: AW] = 8'd63; bi[3*AW +: AW] = 8'd70;
        req(0, 1, 8'd0, bi);
        idle(3);
        load_k(100);
        idle(4);
        req(1, 0, 8'(4 * $urandom_range(0, 63)), rnd_bi(50));
        idle(3);
        for (int k = 0; k <= 10; k++) wr(rnd_cw(), rnd_cw(), k == 10);
        idle(3);
        for (int k = 0; k < DEPTH; k++) wr(rnd_cw(), rnd_cw(), 0);
        idle(2);
        load_rnd();
        idle(2);
        req(1, 0, 8'($urandom), rnd_bi(0));
        idle(3);
        req(1, 1, 8'd3, rnd_bi(0));
        idle(3);
        req(0, 1, 8'd0, rnd_bi(20));
        req(1, 0, 8'd1, '0);
        req(0, 1, 8'd0, rnd_bi(0));
        idle(3);
        req(1, 0, 8'd2, '0);
        cyc(1, 0, 0, '0, '0, 0, 0, 8'd0, '0);
        idle(2);
        load_rnd();
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 1) == 1,
                (m_cnt == DEPTH - 1) || ($urandom_range(0, 63) == 0),
                rnd_cw(), rnd_cw(),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0,
                8'($urandom), rnd_bi(25));
        end
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
